// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter: register
// offsets (word index, mem_addr[3:2]), STATUS bit positions, the 2-bit
// transmitter state encoding and the bit-time helper.
package mmio_uart_tx_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_BUSY    = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // A divider below 2 would make a bit shorter than the reload path allows.
   function automatic logic [15:0] bit_cycles(input logic [15:0] div);
      return (div < 16'd2) ? 16'd2 : div;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo
// Synchronous FIFO used as the UART transmit queue.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   push, din       write request and data (ignored when full unless popping)
//   pop, dout       read request (ignored when empty), head-of-queue data
//   full, empty     occupancy flags
//   count           entries held, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // is still accepted then.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only observed when count > 0.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter on the mcu data bus. CPU byte writes
// to TXDATA are queued in a FIFO and shifted out LSB first on tx.
// Ports:
//   clk, rstn                 system clock, asynchronous active-low reset
//   mem_addr/wdata/wmask      bus write side (wmask != 0 means write)
//   mem_rstrb, mem_rdata      read strobe, registered read data (1-cycle)
//   tx                        serial output, idle high, driven from a flop
//   irq                       only when UART_TX_IRQ_EN is defined
// Optional feature macro: UART_TX_IRQ_EN (CTRL.irq_en and irq port).
//
// state    | meaning
// ST_IDLE  | line idle high, waiting for a queued byte
// ST_START | start bit (tx=0) for one bit time
// ST_DATA  | 8 data bits, LSB first
// ST_STOP  | stop bit (tx=1); chains straight into ST_START if bytes wait
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          BAUD       = 115200,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic        tx
`ifdef UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

   logic          hit, wr_en, push_req;
   logic [1:0]    reg_sel;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;

   logic [15:0]   div_q, div_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   status_w, ctrl_w;
   logic [15:0]   reload_w;

   tx_state_e     state_q;
   logic [15:0]   cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign reg_sel  = mem_addr[3:2];
   assign wr_en    = hit & (|mem_wmask);
   assign push_req = wr_en & (reg_sel == REG_TXDATA) & mem_wmask[0];

   // The head is taken on the cycle the FSM leaves IDLE or finishes a stop
   // bit, which is what gives gap-free back-to-back frames.
   assign fifo_pop = ~fifo_empty &
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (cnt_q == 16'd0)));
   assign reload_w = bit_cycles(div_q) - 16'd1;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (mem_wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef UART_TX_IRQ_EN
   logic irq_en_q, irq_en_d, irq_q, irq_d;

   always_comb begin
      irq_en_d = irq_en_q;
      if (wr_en && (reg_sel == REG_CTRL) && mem_wmask[0]) irq_en_d = mem_wdata[0];
      irq_d = irq_en_q & fifo_empty & (state_q == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq    = irq_q;
   assign ctrl_w = {31'd0, irq_en_q};
`else
   assign ctrl_w = 32'd0;
`endif

   always_comb begin
      status_w                          = 32'd0;
      status_w[STAT_FULL]               = fifo_full;
      status_w[STAT_EMPTY]              = fifo_empty;
      status_w[STAT_BUSY]               = (state_q != ST_IDLE);
      status_w[STAT_OVF]                = ovf_q;
      status_w[STAT_CNT_LSB +: CW]      = fifo_count;
   end

   always_comb begin
      div_d = div_q;
      if (wr_en && (reg_sel == REG_DIV) && (mem_wmask[1:0] == 2'b11)) div_d = mem_wdata[15:0];

      // Set is evaluated after clear so a simultaneous overflow wins.
      ovf_d = ovf_q;
      if (wr_en && (reg_sel == REG_STATUS) && mem_wmask[0] && mem_wdata[STAT_OVF]) ovf_d = 1'b0;
      if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;

      rdata_d = rdata_q;
      if (mem_rstrb && hit) begin
         case (reg_sel)
            REG_STATUS: rdata_d = status_w;
            REG_DIV:    rdata_d = {16'd0, div_q};
            REG_CTRL:   rdata_d = ctrl_w;
            default:    rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_q   <= DIV_RESET;
         ovf_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         div_q   <= div_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
      end
   end

   // Baud down-counter reloads from the live divider at every bit boundary,
   // so a DIV write mid-frame applies from the next bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state_q <= ST_START;
                  tx_q    <= 1'b0;
                  shift_q <= fifo_dout;
                  cnt_q   <= reload_w;
               end
            end
            ST_START: begin
               if (cnt_q == 16'd0) begin
                  state_q   <= ST_DATA;
                  tx_q      <= shift_q[0];
                  shift_q   <= {1'b0, shift_q[7:1]};
                  bit_idx_q <= 3'd0;
                  cnt_q     <= reload_w;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            ST_DATA: begin
               if (cnt_q == 16'd0) begin
                  cnt_q <= reload_w;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= {1'b0, shift_q[7:1]};
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            ST_STOP: begin
               if (cnt_q == 16'd0) begin
                  if (!fifo_empty) begin
                     state_q <= ST_START;
                     tx_q    <= 1'b0;
                     shift_q <= fifo_dout;
                     cnt_q   <= reload_w;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx        = tx_q;
   assign mem_rdata = rdata_q;

   logic unused_bits;
   assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wmask[3:2]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. A line monitor decodes tx frames
// and compares them with bytes queued by the stimulus tasks.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE     = 32'h0040_0000;
   localparam logic [31:0] A_TXDATA = BASE + 32'h0;
   localparam logic [31:0] A_STATUS = BASE + 32'h4;
   localparam logic [31:0] A_DIV    = BASE + 32'h8;
   localparam logic [31:0] A_CTRL   = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wmask = 4'd0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic        tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .CLK_HZ     (50_000_000),
      .BAUD       (115200),
      .FIFO_DEPTH (8)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rstrb (mem_rstrb),
      .mem_rdata (mem_rdata),
      .tx        (tx)
`ifdef UART_TX_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb_q[$];
   int         start_log[$];
   int         last_start = 0;
   bit         mon_en = 1'b0;
   bit         mon_busy = 1'b0;
   int         bit_cyc = 4;

   logic [7:0] mon_data, mon_exp;
   logic       mon_start, mon_stop;

   // Frame decoder: start detected on the first low sample, then each bit
   // sampled near its centre.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && rstn && tx === 1'b0) begin
            mon_busy = 1'b1;
            start_log.push_back(cyc);
            last_start = cyc;
            repeat (bit_cyc / 2) @(negedge clk);
            mon_start = tx;
            for (int k = 0; k < 8; k++) begin
               repeat (bit_cyc) @(negedge clk);
               mon_data[k] = tx;
            end
            repeat (bit_cyc) @(negedge clk);
            mon_stop = tx;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected got=%02h expected=none", mon_data);
            end else begin
               mon_exp = sb_q.pop_front();
               if (mon_data !== mon_exp || mon_start !== 1'b0 || mon_stop !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_data got=%02h start=%b stop=%b expected=%02h start=0 stop=1",
                           mon_data, mon_start, mon_stop, mon_exp);
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      mem_addr  = a;
      mem_wdata = d;
      mem_wmask = m;
      @(negedge clk);
      mem_wmask = 4'd0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      mem_addr  = a;
      mem_rstrb = 1'b1;
      @(negedge clk);
      mem_rstrb = 1'b0;
      d = mem_rdata;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accepted);
      if (accepted) sb_q.push_back(b);
      bus_write(A_TXDATA, {24'd0, b}, 4'b0001);
   endtask

   task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      bus_read(a, rd);
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL %s got=%08h expected=%08h", name, rd, exp);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (bit_cyc + 2) @(negedge clk);
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d expected=0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b expected=1", tx); end
      rstn = 1'b1;
      @(negedge clk);
      check_read("reset_status", A_STATUS, 32'h0000_0002);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx got=%b expected=1", tx); end
      check_read("txdata_reads_zero", A_TXDATA, 32'd0);
      check_read("reset_ctrl", A_CTRL, 32'd0);
      check_read("reset_div", A_DIV, 32'd434);
      check_read("unhit_read_holds", 32'h0050_0004, 32'd434);
   endtask

   task automatic test_single_frame();
      bit seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int bad = 0;
      bus_write(A_DIV, 32'h0000_0009, 4'b0001);
      check_read("div_partial_mask", A_DIV, 32'd434);
      bus_write(A_DIV, 32'd4, 4'b0011);
      check_read("div_write", A_DIV, 32'd4);
      bit_cyc = 4;
      mon_en  = 1'b1;
      push_byte(8'hA5, 1'b1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx !== seq[i / 4]) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL a5_waveform bad_cycles=%0d expected=0", bad); end
      @(negedge clk);
      check_read("idle_after_frame", A_STATUS, 32'h0000_0002);
      push_byte(8'h3C, 1'b1);
      repeat (5) @(negedge clk);
      check_read("busy_mid_frame", A_STATUS, 32'h0000_0006);
      wait_drain(200);
      check_read("idle_after_drain", A_STATUS, 32'h0000_0002);
   endtask

   task automatic test_overflow_and_full_pushpop();
      int n = 0;
      int bad = 0;
      start_log.delete();
      for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b1);
      check_read("count7", A_STATUS, 32'h0000_0704);
      push_byte(8'h18, 1'b1);
      push_byte(8'h19, 1'b0);
      check_read("full_overflow", A_STATUS, 32'h0000_080D);
      bus_write(A_STATUS, 32'h0000_0008, 4'b0001);
      check_read("ovf_w1c", A_STATUS, 32'h0000_0805);
      // Time a push onto the exact edge where the stop bit ends and the FIFO pops.
      while (cyc < last_start + 39 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cyc != last_start + 39) begin
         errors++;
         $display("FAIL pushpop_alignment got=%0d expected=%0d", cyc, last_start + 39);
      end
      push_byte(8'h5A, 1'b1);
      check_read("pushpop_full", A_STATUS, 32'h0000_0805);
      wait_drain(1000);
      checks++;
      if (start_log.size() != 10) begin
         errors++;
         $display("FAIL burst_frames got=%0d expected=10", start_log.size());
      end
      for (int i = 1; i < start_log.size(); i++)
         if (start_log[i] - start_log[i-1] != 40) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL burst_gaps bad=%0d expected=0", bad); end
   endtask

   task automatic test_div_min();
      bus_write(A_DIV, 32'd1, 4'b0011);
      bit_cyc = 2;
      start_log.delete();
      push_byte(8'h96, 1'b1);
      push_byte(8'h41, 1'b1);
      wait_drain(200);
      checks++;
      if (start_log.size() != 2 || start_log[1] - start_log[0] != 20) begin
         errors++;
         $display("FAIL div_min_timing frames=%0d expected=2 gap=20", start_log.size());
      end
      bus_write(A_DIV, 32'd4, 4'b0011);
      bit_cyc = 4;
   endtask

   task automatic test_reset_mid_frame();
      int n = 0;
      int s;
      int bad = 0;
      mon_en = 1'b0;
      push_byte(8'h00, 1'b0);
      while (tx !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      s = cyc;
      while (cyc < s + 17) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL data_bit3_low got=%b expected=0", tx); end
      rstn = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got=%b expected=1", tx); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_read("post_reset_status", A_STATUS, 32'h0000_0002);
      check_read("post_reset_div", A_DIV, 32'd434);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL spurious_frame low_cycles=%0d expected=0", bad); end
      bus_write(A_DIV, 32'd4, 4'b0011);
      bit_cyc = 4;
      mon_en  = 1'b1;
   endtask

   task automatic test_ctrl_irq();
`ifdef UART_TX_IRQ_EN
      int bad = 0;
      bus_write(A_CTRL, 32'd1, 4'b0001);
      check_read("ctrl_rw", A_CTRL, 32'd1);
      push_byte(8'hC3, 1'b1);
      for (int i = 1; i <= 41; i++) begin
         @(negedge clk);
         if (irq !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL irq_during_frame high_cycles=%0d expected=0", bad); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_frame got=%b expected=1", irq); end
      bus_write(A_CTRL, 32'd0, 4'b0001);
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable got=%b expected=0", irq); end
      wait_drain(100);
`else
      bus_write(A_CTRL, 32'd1, 4'b0001);
      check_read("ctrl_ignored", A_CTRL, 32'd0);
`endif
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_overflow_and_full_pushpop();
      test_div_min();
      test_reset_mid_frame();
      test_ctrl_irq();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
